// File: rtl/alu_exec_unit.sv
// Registered ALU execute stage with valid/ready handshakes on both sides.
// Define ALU_EXEC_FAST_SHIFT_EN for a single-cycle barrel shifter; default is iterative SLL/SRL.
module alu_exec_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [3:0]             alu_operation_i,
    input  logic [DATA_WIDTH-1:0]  a_i,
    input  logic [DATA_WIDTH-1:0]  b_i,
    input  logic [SHAMT_WIDTH-1:0] shamt_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [DATA_WIDTH-1:0]  result_o,
    output logic                   zero_o,
    output logic                   overflow_o
);

    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_LUI  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_NOR  = 4'h8;
    localparam logic [3:0] OP_ADDR = 4'h9;
    localparam logic [3:0] OP_JR   = 4'hA;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DONE  = 2'd1;
`ifndef ALU_EXEC_FAST_SHIFT_EN
    localparam logic [1:0] ST_SHIFT = 2'd2;
`endif

    logic [1:0]            state;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic [DATA_WIDTH-1:0] op_result;
    logic                  op_overflow;
    logic                  a_sign;
    logic                  b_sign;

    assign sum    = a_i + b_i;
    assign diff   = a_i - b_i;
    assign a_sign = a_i[DATA_WIDTH-1];
    assign b_sign = b_i[DATA_WIDTH-1];

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        op_result   = '0;
        op_overflow = 1'b0;
        case (alu_operation_i)
            OP_SUB: begin
                op_result   = diff;
                op_overflow = (a_sign != b_sign) && (diff[DATA_WIDTH-1] != a_sign);
            end
            OP_ADD, OP_ADDR: begin
                op_result   = sum;
                op_overflow = (a_sign == b_sign) && (sum[DATA_WIDTH-1] != a_sign);
            end
            OP_OR:  op_result = a_i | b_i;
            OP_LUI: op_result = {b_i[15:0], {(DATA_WIDTH-16){1'b0}}};
`ifdef ALU_EXEC_FAST_SHIFT_EN
            OP_SLL: op_result = b_i << shamt_i;
            OP_SRL: op_result = b_i >> shamt_i;
`else
            // Only reached with shamt_i == 0; nonzero shifts go through ST_SHIFT.
            OP_SLL, OP_SRL: op_result = b_i;
`endif
            OP_AND: op_result = a_i & b_i;
            OP_NOR: op_result = ~(a_i | b_i);
            OP_JR:  op_result = a_i;
            default: ;
        endcase
    end

    assign ready_o = reset & ((state == ST_IDLE) | ((state == ST_DONE) & ready_i));
    assign accept  = valid_i & ready_o;
    assign valid_o = (state == ST_DONE);
    assign zero_o  = (result_o == '0);

`ifndef ALU_EXEC_FAST_SHIFT_EN
    logic [DATA_WIDTH-1:0]  acc;
    logic [DATA_WIDTH-1:0]  acc_next;
    logic [SHAMT_WIDTH-1:0] cnt;
    logic                   shift_right;
    logic                   start_shift;

    assign start_shift = ((alu_operation_i == OP_SLL) || (alu_operation_i == OP_SRL))
                         && (shamt_i != '0);
    assign acc_next    = shift_right ? (acc >> 1) : (acc << 1);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            result_o   <= '0;
            overflow_o <= 1'b0;
`ifndef ALU_EXEC_FAST_SHIFT_EN
            acc         <= '0;
            cnt         <= '0;
            shift_right <= 1'b0;
`endif
        end else if (accept) begin
            state      <= ST_DONE;
            result_o   <= op_result;
            overflow_o <= op_overflow;
`ifndef ALU_EXEC_FAST_SHIFT_EN
            if (start_shift) begin
                state       <= ST_SHIFT;
                acc         <= b_i;
                cnt         <= shamt_i;
                shift_right <= (alu_operation_i == OP_SRL);
            end
`endif
        end else begin
            case (state)
`ifndef ALU_EXEC_FAST_SHIFT_EN
                ST_SHIFT: begin
                    acc <= acc_next;
                    cnt <= cnt - SHAMT_WIDTH'(1);
                    if (cnt == SHAMT_WIDTH'(1)) begin
                        result_o   <= acc_next;
                        overflow_o <= 1'b0;
                        state      <= ST_DONE;
                    end
                end
`endif
                ST_DONE: if (ready_i) state <= ST_IDLE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: arithmetic reference model, per-cycle compare, directed vectors.
// Honours ALU_EXEC_FAST_SHIFT_EN for the expected shift latency.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [3:0]  op = 4'h0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  sh = '0;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic        zero_o;
    logic        overflow_o;

    int n_checks = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];

    alu_exec_unit #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk(clk),
        .reset(reset),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .alu_operation_i(op),
        .a_i(a),
        .b_i(b),
        .shamt_i(sh),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .result_o(result_o),
        .zero_o(zero_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    // Overflow judged by whether the exact signed result fits in 32 bits.
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                   input logic [4:0] s);
        exp_t   e;
        longint sx;
        longint sy;
        longint r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = 0;
        e.res = '0;
        e.ovf = 1'b0;
        case (o)
            4'h1: begin r = sx - sy; e.res = x - y; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'h3, 4'h9: begin r = sx + sy; e.res = x + y; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'h2: e.res = x | y;
            4'h4: e.res = y * 32'h10000;
            4'h5: e.res = y << s;
            4'h6: e.res = y >> s;
            4'h7: e.res = x & y;
            4'h8: e.res = ~(x | y);
            4'hA: e.res = x;
            default: e.res = '0;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle a result is presented it must match the oldest outstanding request.
    always begin
        @(negedge clk);
        #2;
        if (reset && cmp_en && valid_o) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", {31'd0, valid_o}, 32'd0);
            end else begin
                check("cmp_result", result_o, exp_q[0].res);
                check("cmp_overflow", {31'd0, overflow_o}, {31'd0, exp_q[0].ovf});
                check("cmp_zero", {31'd0, zero_o}, {31'd0, exp_q[0].res == 32'd0});
                if (ready_i) void'(exp_q.pop_front());
            end
        end
    end

    // Presents a request at a negedge and returns just after the edge that accepts it.
    task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] s, input logic rdy);
        int waited;
        waited = 0;
        @(negedge clk);
        valid_i = 1'b1;
        op = o;
        a = x;
        b = y;
        sh = s;
        ready_i = rdy;
        #1;
        while (!ready_o && waited < 100) begin
            @(negedge clk);
            ready_i = 1'b1;
            #1;
            waited++;
        end
        check("accept", {31'd0, ready_o}, 32'd1);
        if (ready_o) exp_q.push_back(model(o, x, y, s));
        @(posedge clk);
    endtask

    task automatic drop();
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            valid_i = 1'b0;
            ready_i = 1'b1;
            k++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    // Counts edges from the accepting edge (counted as 1) until valid_o is seen.
    task automatic measure_latency(output int lat);
        lat = 1;
        @(negedge clk);
        valid_i = 1'b0;
        #2;
        while (!valid_o && lat < 100) begin
            check("ready_low_in_shift", {31'd0, ready_o}, 32'd0);
            @(negedge clk);
            #2;
            lat++;
        end
    endtask

    typedef struct {
        logic [3:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  s;
    } vec_t;

    vec_t vecs[15];

    initial begin
        exp_t m;
        int   lat;

        vecs[0]  = '{4'h7, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0};
        vecs[1]  = '{4'h8, 32'h00000000, 32'h00000000, 5'd0};
        vecs[2]  = '{4'h8, 32'h12345678, 32'h0F0F0000, 5'd0};
        vecs[3]  = '{4'hA, 32'h00400020, 32'h0000FFFF, 5'd0};
        vecs[4]  = '{4'h9, 32'h80000000, 32'h80000000, 5'd0};
        vecs[5]  = '{4'h1, 32'h80000000, 32'h00000001, 5'd0};
        vecs[6]  = '{4'h1, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0};
        vecs[7]  = '{4'h0, 32'h00000005, 32'h00000006, 5'd3};
        vecs[8]  = '{4'hF, 32'h00000005, 32'h00000006, 5'd3};
        vecs[9]  = '{4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0};
        vecs[10] = '{4'h6, 32'h00000000, 32'h80000000, 5'd0};
        vecs[11] = '{4'h5, 32'h00000000, 32'hA5A5A5A5, 5'd4};
        vecs[12] = '{4'h6, 32'h00000000, 32'h80000001, 5'd31};
        vecs[13] = '{4'h3, 32'h00000001, 32'hFFFFFFFF, 5'd0};
        vecs[14] = '{4'h2, 32'h00000000, 32'h00000000, 5'd0};

        // Reset held with a pending request.
        reset = 1'b0;
        valid_i = 1'b1;
        ready_i = 1'b1;
        op = 4'h3;
        a = 32'd1;
        b = 32'd1;
        repeat (2) begin
            @(negedge clk);
            #2;
            check("rst_ready", {31'd0, ready_o}, 32'd0);
            check("rst_valid", {31'd0, valid_o}, 32'd0);
            check("rst_result", result_o, 32'd0);
            check("rst_zero", {31'd0, zero_o}, 32'd1);
        end
        @(negedge clk);
        reset = 1'b1;
        valid_i = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, ready_o}, 32'd1);
        cmp_en = 1'b1;

        // Hand-computed values that pin the reference model.
        m = model(4'h3, 32'h7FFFFFFF, 32'h1, 5'd0);
        check("model_add_res", m.res, 32'h80000000);
        check("model_add_ovf", {31'd0, m.ovf}, 32'd1);
        m = model(4'h1, 32'h80000000, 32'h1, 5'd0);
        check("model_sub_ovf", {31'd0, m.ovf}, 32'd1);
        m = model(4'h4, 32'h0, 32'h1234, 5'd0);
        check("model_lui", m.res, 32'h12340000);
        m = model(4'h8, 32'h0, 32'h0, 5'd0);
        check("model_nor", m.res, 32'hFFFFFFFF);
        m = model(4'h6, 32'h0, 32'h80000001, 5'd31);
        check("model_srl", m.res, 32'h00000001);

        // ADD overflow, latency 1.
        send(4'h3, 32'h7FFFFFFF, 32'h1, 5'd0, 1'b1);
        measure_latency(lat);
        check("add_latency", lat, 32'd1);
        check("add_result", result_o, 32'h80000000);
        check("add_overflow", {31'd0, overflow_o}, 32'd1);
        check("add_zero", {31'd0, zero_o}, 32'd0);

        // SUB then OR back-to-back.
        send(4'h1, 32'd5, 32'd5, 5'd0, 1'b1);
        #2;
        check("sub_valid", {31'd0, valid_o}, 32'd1);
        check("sub_result", result_o, 32'd0);
        check("sub_zero", {31'd0, zero_o}, 32'd1);
        send(4'h2, 32'hF0, 32'h0F, 5'd0, 1'b1);
        #2;
        check("or_valid", {31'd0, valid_o}, 32'd1);
        check("or_result", result_o, 32'hFF);

        // SLL by 31.
        send(4'h5, 32'h0, 32'h1, 5'd31, 1'b1);
        measure_latency(lat);
`ifdef ALU_EXEC_FAST_SHIFT_EN
        check("sll_latency", lat, 32'd1);
`else
        check("sll_latency", lat, 32'd32);
`endif
        check("sll_result", result_o, 32'h80000000);
        drain();

        // LUI held while downstream stalls.
        send(4'h4, 32'h0, 32'h1234, 5'd0, 1'b0);
        drop();
        for (int i = 0; i < 3; i++) begin
            #2;
            check("lui_hold_valid", {31'd0, valid_o}, 32'd1);
            check("lui_hold_result", result_o, 32'h12340000);
            @(negedge clk);
        end
        ready_i = 1'b1;
        @(negedge clk);
        #2;
        check("lui_retired", {31'd0, valid_o}, 32'd0);

        // Directed table with a stalling downstream pattern.
        for (int i = 0; i < 15; i++) begin
            send(vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].s, (i % 3) != 2);
        end
        drop();
        drain();

        // SRL interrupted by reset; nothing may come out.
        send(4'h6, 32'h0, 32'h80000000, 5'd8, 1'b1);
        drop();
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        cmp_en = 1'b1;
        #1;
        check("abort_ready", {31'd0, ready_o}, 32'd1);
        check("abort_valid", {31'd0, valid_o}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #2;
            check("abort_no_valid", {31'd0, valid_o}, 32'd0);
        end
        send(4'hA, 32'h00400020, 32'h0, 5'd0, 1'b1);
        measure_latency(lat);
        check("jr_latency", lat, 32'd1);
        check("jr_result", result_o, 32'h00400020);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
